// File: rtl/mont_pkg.sv
// mont_pkg: shared definitions for the Montgomery exponentiation sequencer.
//   - mont_exp_state_t and the ST_* state codes
//   - MONT_ONE: the constant 1 used as the "b" operand to enter/leave the
//     Montgomery domain
//   - width helpers for the m_size / exp_size / bit-index fields
package mont_pkg;

  localparam int MONT_NBITS_DEF = 2048;

  typedef logic [2:0] mont_exp_state_t;

  localparam mont_exp_state_t ST_IDLE      = 3'd0;
  localparam mont_exp_state_t ST_TO_MONT   = 3'd1;
  localparam mont_exp_state_t ST_INIT_ACC  = 3'd2;
  localparam mont_exp_state_t ST_LOOP_SQ   = 3'd3;
  localparam mont_exp_state_t ST_LOOP_MUL  = 3'd4;
  localparam mont_exp_state_t ST_FROM_MONT = 3'd5;
  localparam mont_exp_state_t ST_DONE      = 3'd6;

  localparam logic [MONT_NBITS_DEF-1:0] MONT_ONE = MONT_NBITS_DEF'(1);

  function automatic int m_size_width(input int nbits);
    return $clog2(nbits) + 3;
  endfunction

  function automatic int exp_size_width(input int ebits);
    return $clog2(ebits) + 1;
  endfunction

  // Width of the exponent bit index (0..ebits-1).
  function automatic int bit_idx_width(input int ebits);
    return (ebits > 1) ? $clog2(ebits) : 1;
  endfunction

endpackage

// File: rtl/mont_op_issue.sv
// mont_op_issue: one-operation-at-a-time handshake with montgomery_mul.
//   issue_p        : request (from sequencer) to start an operation with a_in/b_in
//   mul_enable_p   : registered single-cycle start pulse to the multiplier (ISSUE)
//   mul_a/mul_b    : registered operands, held until the operation completes
//   mul_y          : multiplier result
//   mul_done_irq_p : multiplier completion; honoured only in the WAIT sub-phase
//   op_done_p      : completion pulse back to the sequencer, same cycle as the
//                    accepted mul_done_irq_p
//   op_y           : result to be captured on op_done_p
module mont_op_issue #(
  parameter int NBITS = 2048
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_p,
  input  logic [NBITS-1:0] a_in,
  input  logic [NBITS-1:0] b_in,
  output logic             mul_enable_p,
  output logic [NBITS-1:0] mul_a,
  output logic [NBITS-1:0] mul_b,
  input  logic [NBITS-1:0] mul_y,
  input  logic             mul_done_irq_p,
  output logic             op_done_p,
  output logic [NBITS-1:0] op_y
);

  logic en_q;
  logic wait_q;

  // A done pulse seen during the ISSUE cycle (en_q) or while idle is dropped.
  assign op_done_p    = wait_q & mul_done_irq_p;
  assign op_y         = mul_y;
  assign mul_enable_p = en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      wait_q <= 1'b0;
      mul_a  <= '0;
      mul_b  <= '0;
    end else begin
      if (issue_p) begin
        en_q   <= 1'b1;
        wait_q <= 1'b0;
        mul_a  <= a_in;
        mul_b  <= b_in;
      end else if (en_q) begin
        en_q   <= 1'b0;
        wait_q <= 1'b1;
      end else if (op_done_p) begin
        wait_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl: y = base^exp mod m by left-to-right square-and-multiply,
// driving one external montgomery_mul through mont_op_issue.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start_p               start pulse, accepted only in IDLE
//   base, exp, m, r2_red  operands (base < m, m odd, r2_red = R^2 mod m)
//   m_size, exp_size      modulus size (passed through), exponent bits to use
//   mul_*                 multiplier interface (enable/operands/result/done)
//   y                     result, held until overwritten by the next job
//   busy, done_irq_p      status / completion pulse
//
// Build option: MONT_EXP_CONST_TIME_EN -- run LOOP_MUL on every exponent bit and
// discard the product for zero bits, so the operation count does not depend
// on the exponent value.
//
// state        | meaning
// IDLE         | waiting for start_p
// TO_MONT      | bm  = base * R mod m
// INIT_ACC     | acc = R mod m (Montgomery 1)
// LOOP_SQ      | acc = acc^2
// LOOP_MUL     | acc = acc * bm (kept only for exp[i]==1)
// FROM_MONT    | y = acc * R^-1 mod m
// DONE         | done_irq_p for one cycle
module mont_exp_ctrl
  import mont_pkg::*;
#(
  parameter int NBITS = MONT_NBITS_DEF,
  parameter int EBITS = NBITS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_p,
  input  logic [NBITS-1:0]           base,
  input  logic [EBITS-1:0]           exp,
  input  logic [NBITS-1:0]           m,
  input  logic [NBITS-1:0]           r2_red,
  input  logic [$clog2(NBITS)+2:0]   m_size,
  input  logic [$clog2(EBITS):0]     exp_size,
  output logic                       mul_enable_p,
  output logic [NBITS-1:0]           mul_a,
  output logic [NBITS-1:0]           mul_b,
  output logic [NBITS-1:0]           mul_m,
  output logic [$clog2(NBITS)+2:0]   mul_m_size,
  input  logic [NBITS-1:0]           mul_y,
  input  logic                       mul_done_irq_p,
  output logic [NBITS-1:0]           y,
  output logic                       busy,
  output logic                       done_irq_p
);

  localparam int MSW = m_size_width(NBITS);
  localparam int ESW = exp_size_width(EBITS);
  localparam int IW  = bit_idx_width(EBITS);
  localparam logic [NBITS-1:0] ONE = NBITS'(MONT_ONE);
`ifdef MONT_EXP_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  mont_exp_state_t  state_q, state_d;
  logic [NBITS-1:0] acc_q, acc_d, bm_q, bm_d, y_q, y_d, r2_q, m_q;
  logic [EBITS-1:0] exp_q;
  logic [ESW-1:0]   exp_size_q, exp_size_sat;
  logic [MSW-1:0]   m_size_q;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d, capture;
  logic             issue_p, op_done_p, step;
  logic [NBITS-1:0] op_a, op_b, op_y, step_val;

  assign exp_size_sat = (exp_size > ESW'(EBITS)) ? ESW'(EBITS) : exp_size;

  mont_op_issue #(.NBITS(NBITS)) u_issue (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_p        (issue_p),
    .a_in           (op_a),
    .b_in           (op_b),
    .mul_enable_p   (mul_enable_p),
    .mul_a          (mul_a),
    .mul_b          (mul_b),
    .mul_y          (mul_y),
    .mul_done_irq_p (mul_done_irq_p),
    .op_done_p      (op_done_p),
    .op_y           (op_y)
  );

  // The next operation is issued in the same cycle the previous one completes,
  // so operands that depend on that result are taken straight from op_y.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    acc_d    = acc_q;
    bm_d     = bm_q;
    y_d      = y_q;
    idx_d    = idx_q;
    capture  = 1'b0;
    issue_p  = 1'b0;
    op_a     = acc_q;
    op_b     = acc_q;
    step     = 1'b0;
    step_val = acc_q;
    case (state_q)
      ST_IDLE: if (start_p) begin
        capture = 1'b1;
        busy_d  = 1'b1;
        issue_p = 1'b1;
        op_a    = base;
        op_b    = r2_red;
        state_d = ST_TO_MONT;
      end
      ST_TO_MONT: if (op_done_p) begin
        bm_d    = op_y;
        issue_p = 1'b1;
        op_a    = r2_q;
        op_b    = ONE;
        state_d = ST_INIT_ACC;
      end
      ST_INIT_ACC: if (op_done_p) begin
        acc_d   = op_y;
        issue_p = 1'b1;
        op_a    = op_y;
        if (exp_size_q == '0) begin
          op_b    = ONE;
          state_d = ST_FROM_MONT;
        end else begin
          op_b    = op_y;
          idx_d   = IW'(exp_size_q - ESW'(1));
          state_d = ST_LOOP_SQ;
        end
      end
      ST_LOOP_SQ: if (op_done_p) begin
        acc_d = op_y;
        if (CONST_TIME || exp_q[idx_q]) begin
          issue_p = 1'b1;
          op_a    = op_y;
          op_b    = bm_q;
          state_d = ST_LOOP_MUL;
        end else begin
          step     = 1'b1;
          step_val = op_y;
        end
      end
      ST_LOOP_MUL: if (op_done_p) begin
        // Dummy multiply for a zero bit: keep the squared value.
        step     = 1'b1;
        step_val = (CONST_TIME && !exp_q[idx_q]) ? acc_q : op_y;
        acc_d    = step_val;
      end
      ST_FROM_MONT: if (op_done_p) begin
        y_d     = op_y;
        busy_d  = 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Finish the current exponent bit: next square, or leave the loop.
    if (step) begin
      issue_p = 1'b1;
      op_a    = step_val;
      if (idx_q == '0) begin
        op_b    = ONE;
        state_d = ST_FROM_MONT;
      end else begin
        op_b    = step_val;
        idx_d   = idx_q - IW'(1);
        state_d = ST_LOOP_SQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      acc_q      <= '0;
      bm_q       <= '0;
      y_q        <= '0;
      idx_q      <= '0;
      r2_q       <= '0;
      m_q        <= '0;
      exp_q      <= '0;
      exp_size_q <= '0;
      m_size_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      acc_q   <= acc_d;
      bm_q    <= bm_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      if (capture) begin
        r2_q       <= r2_red;
        m_q        <= m;
        exp_q      <= exp;
        exp_size_q <= exp_size_sat;
        m_size_q   <= m_size;
      end
    end
  end

  assign mul_m      = m_q;
  assign mul_m_size = m_size_q;
  assign y          = y_q;
  assign busy       = busy_q;
  assign done_irq_p = (state_q == ST_DONE);

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// tb_mont_exp_ctrl: randomized scoreboard bench for mont_exp_ctrl (NBITS=EBITS=16).
// A behavioural montgomery_mul (R = 2^16, random latency) answers the DUT;
// expected results come from plain modular exponentiation.
module tb_mont_exp_ctrl;

  localparam int NB  = 16;
  localparam int EB  = 16;
  localparam int MSW = 7;
  localparam int ESW = 5;
`ifdef MONT_EXP_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_p = 1'b0;
  logic [NB-1:0]  base = '0, m = '0, r2_red = '0;
  logic [EB-1:0]  exp = '0;
  logic [MSW-1:0] m_size = '0;
  logic [ESW-1:0] exp_size = '0;
  logic           mul_enable_p;
  logic [NB-1:0]  mul_a, mul_b, mul_m, mul_y;
  logic [MSW-1:0] mul_m_size;
  logic           mul_done_irq_p;
  logic [NB-1:0]  y;
  logic           busy, done_irq_p;

  int checks = 0;
  int errors = 0;
  int ops = 0;
  int dones = 0;
  bit inject_issue_done = 1'b0;
  logic [NB-1:0]  cur_m = '0;
  logic [MSW-1:0] cur_msize = '0;

  typedef struct {
    logic [NB-1:0] y;
    int            ops;
  } exp_t;
  exp_t sb[$];
  exp_t sbx;

  int            pend = 0;
  logic [NB-1:0] pa, pb, pm;

  always #5 clk = ~clk;

  mont_exp_ctrl #(.NBITS(NB), .EBITS(EB)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_p        (start_p),
    .base           (base),
    .exp            (exp),
    .m              (m),
    .r2_red         (r2_red),
    .m_size         (m_size),
    .exp_size       (exp_size),
    .mul_enable_p   (mul_enable_p),
    .mul_a          (mul_a),
    .mul_b          (mul_b),
    .mul_m          (mul_m),
    .mul_m_size     (mul_m_size),
    .mul_y          (mul_y),
    .mul_done_irq_p (mul_done_irq_p),
    .y              (y),
    .busy           (busy),
    .done_irq_p     (done_irq_p)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // a*b*2^-16 mod mm, bit-serial reduction.
  function automatic longint montmul(input longint a, input longint b, input longint mm);
    longint t;
    t = a * b;
    for (int k = 0; k < NB; k++) begin
      if ((t % 2) == 1) t = t + mm;
      t = t / 2;
    end
    if (t >= mm) t = t - mm;
    return t;
  endfunction

  function automatic longint ref_modexp(input longint b, input longint e, input longint mm);
    longint r;
    r = 1 % mm;
    for (longint k = 0; k < e; k++) r = (r * b) % mm;
    return r;
  endfunction

  // Behavioural multiplier.
  initial begin
    mul_done_irq_p = 1'b0;
    mul_y = '0;
    forever begin
      @(posedge clk); #1;
      mul_done_irq_p = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (busy) check("operands_held", {mul_a, mul_b}, {pa, pb});
          mul_y = NB'(montmul(longint'(pa), longint'(pb), longint'(pm)));
          mul_done_irq_p = 1'b1;
        end
      end
      if (mul_enable_p) begin
        ops++;
        pa = mul_a;
        pb = mul_b;
        pm = mul_m;
        pend = $urandom_range(1, 4);
        check("mul_m", mul_m, cur_m);
        check("mul_m_size", mul_m_size, cur_msize);
        if (inject_issue_done) begin
          mul_y = 16'hBEEF;
          mul_done_irq_p = 1'b1;
        end
      end
    end
  end

  // Monitor: compare each completion against the scoreboard.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (done_irq_p) begin
        dones++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done_irq_p with no job outstanding, required none");
        end else begin
          sbx = sb.pop_front();
          check("result_y", y, sbx.y);
          check("op_count", ops, sbx.ops);
          check("busy_at_done", busy, 0);
          ops = 0;
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_y"}, y, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done_irq_p, 0);
    check({tag, "_enable"}, mul_enable_p, 0);
    check({tag, "_mul_a"}, mul_a, 0);
    check({tag, "_mul_b"}, mul_b, 0);
    check({tag, "_mul_m"}, mul_m, 0);
    check({tag, "_mul_m_size"}, mul_m_size, 0);
  endtask

  task automatic wait_done(input int d0, input string tag);
    int n;
    n = 0;
    while (dones == d0 && n < 2000) begin
      @(posedge clk); #2;
      n++;
    end
    if (dones == d0) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: no done_irq_p after %0d cycles, required one", tag, n);
    end
  endtask

  task automatic drive_job(input logic [NB-1:0] b, input logic [EB-1:0] e,
                           input logic [ESW-1:0] es, input logic [NB-1:0] mm);
    base     = b;
    exp      = e;
    exp_size = es;
    m        = mm;
    r2_red   = NB'((longint'(1) << (2 * NB)) % longint'(mm));
    m_size   = MSW'($urandom_range(0, 127));
  endtask

  // restart_at > 0: pulse a second start_p with other operands mid-run.
  task automatic run_job(input logic [NB-1:0] b, input logic [EB-1:0] e,
                         input logic [ESW-1:0] es, input logic [NB-1:0] mm,
                         input int restart_at, input string tag);
    exp_t   x;
    int     es_sat, d0;
    longint em;
    es_sat = (int'(es) > EB) ? EB : int'(es);
    em     = longint'(e) & ((longint'(1) << es_sat) - 1);
    x.y    = NB'(ref_modexp(longint'(b), em, longint'(mm)));
    x.ops  = 3 + es_sat + (CT ? es_sat : $countones(em));
    @(posedge clk); #2;
    drive_job(b, e, es, mm);
    cur_m     = mm;
    cur_msize = m_size;
    ops = 0;
    sb.push_back(x);
    d0 = dones;
    start_p = 1'b1;
    @(posedge clk); #2;
    start_p = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    if (restart_at > 0) begin
      repeat (restart_at) @(posedge clk);
      #2;
      drive_job(b ^ 16'h0001, ~e, 5'd16, 16'h00FB);
      start_p = 1'b1;
      @(posedge clk); #2;
      start_p = 1'b0;
    end
    wait_done(d0, tag);
    repeat (3) @(posedge clk);
    #2;
    check({tag, "_single_done"}, dones - d0, 1);
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] mm, b, y0;
    int d0, n;

    // Reset
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_zero("reset");
    rst_n = 1'b1;

    // Directed jobs
    run_job(16'd3, 16'd5, 5'd3, 16'd13, 0, "basic");
    run_job(16'd7, 16'h1234, 5'd0, 16'd13, 0, "exp_size0");
    run_job(16'd2, 16'h00FF, 5'd8, 16'hFFF1, 0, "all_ones");
    run_job(16'd2, 16'h0000, 5'd8, 16'hFFF1, 0, "all_zero");
    run_job(16'd5, 16'hA5C3, 5'd20, 16'hFFF1, 0, "sat");
    run_job(16'd9, 16'h00B7, 5'd8, 16'hFFF1, 4, "restart");

    // Abort during the first LOOP_SQ (third operation)
    @(posedge clk); #2;
    drive_job(16'd3, 16'd5, 5'd3, 16'd13);
    cur_m = m;
    cur_msize = m_size;
    ops = 0;
    d0 = dones;
    start_p = 1'b1;
    @(posedge clk); #2;
    start_p = 1'b0;
    n = 0;
    while (ops < 3 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    check("abort_reached_loop_sq", ops, 3);
    rst_n = 1'b0;
    #1;
    check_zero("abort_async");
    @(posedge clk); #2;
    check_zero("abort_edge");
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    check("abort_no_done", dones - d0, 0);
    check("abort_no_enable", ops, 3);
    check("abort_busy", busy, 0);
    run_job(16'd3, 16'd5, 5'd3, 16'd13, 0, "after_abort");

    // Spurious multiplier completion while idle
    y0 = y;
    d0 = dones;
    ops = 0;
    @(posedge clk); #2;
    mul_y = 16'h1234;
    mul_done_irq_p = 1'b1;
    @(posedge clk); #2;
    mul_done_irq_p = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("idle_spur_y", y, y0);
    check("idle_spur_busy", busy, 0);
    check("idle_spur_done", dones - d0, 0);
    check("idle_spur_enable", ops, 0);
    run_job(16'd4, 16'h0013, 5'd5, 16'd1009, 0, "after_idle_spur");

    // Spurious completion in every ISSUE cycle
    inject_issue_done = 1'b1;
    run_job(16'd11, 16'h002D, 5'd6, 16'd1009, 0, "issue_spur");
    inject_issue_done = 1'b0;

    // Random jobs
    for (int j = 0; j < 12; j++) begin
      mm = NB'($urandom_range(3, 65535)) | NB'(1);
      b  = NB'($urandom % int'(mm));
      run_job(b, EB'($urandom), ESW'($urandom_range(0, 18)), mm, 0, "rand");
    end

    repeat (5) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mont_exp_ctrl.md
Name: mont_exp_ctrl

Overview:
- Sequencer for modular exponentiation y = base^exp mod m, using left-to-right square-and-multiply.
- Drives one external montgomery_mul instance through its enable_p/done_irq_p handshake, one operation at a time.
- Handles conversion into the Montgomery domain, the exponent loop, and conversion back out.
- Sits between the crypto register block and the shared multiplier datapath.

Parameters:
- NBITS, 2048, operand/modulus width; must match the attached montgomery_mul.
- EBITS, NBITS, exponent width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start_p  input  1  single-cycle start pulse
- base  input  NBITS  base, already reduced (< m)
- exp  input  EBITS  exponent
- m  input  NBITS  odd modulus
- r2_red  input  NBITS  R^2 mod m
- m_size  input  $clog2(NBITS)+3  modulus size, passed through to the multiplier
- exp_size  input  $clog2(EBITS)+1  number of exponent bits to process, 0..EBITS
- mul_enable_p  output  1  single-cycle start pulse to the multiplier
- mul_a  output  NBITS  multiplier operand a
- mul_b  output  NBITS  multiplier operand b
- mul_m  output  NBITS  registered copy of m
- mul_m_size  output  $clog2(NBITS)+3  registered copy of m_size
- mul_y  input  NBITS  multiplier result
- mul_done_irq_p  input  1  multiplier completion pulse
- y  output  NBITS  final result, held until the next start
- busy  output  1  high from the cycle after start_p until done_irq_p
- done_irq_p  output  1  single-cycle completion pulse

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-low (rst_n).
- Reset values: all outputs and registers 0; state IDLE.
- Operand capture: on start_p in IDLE, latch base, exp, m, r2_red, m_size, exp_size; set busy the next cycle. start_p while busy is ignored.
- FSM states: IDLE, TO_MONT, INIT_ACC, LOOP_SQ, LOOP_MUL, FROM_MONT, DONE.
- Issue/wait rule: each operational state has an ISSUE sub-phase then a WAIT sub-phase.
  - ISSUE: drive mul_a/mul_b and pulse mul_enable_p for exactly one cycle.
  - WAIT: wait for mul_done_irq_p, then capture mul_y on that cycle.
  - mul_a/mul_b are held stable from the ISSUE cycle until mul_done_irq_p.
- TO_MONT: a=base, b=r2_red; result goes to bm (base in Montgomery form).
- INIT_ACC: a=r2_red, b=1; result goes to acc (R mod m).
- Loop setup: bit index i = exp_size-1. If exp_size==0, jump to FROM_MONT.
- LOOP_SQ: a=acc, b=acc; result to acc. Then go to LOOP_MUL if exp[i]==1; otherwise decrement i.
- LOOP_MUL: a=acc, b=bm; result to acc; then decrement i.
- Loop exit: after processing i==0, go to FROM_MONT.
- FROM_MONT: a=acc, b=1; result to y.
- DONE: pulse done_irq_p for one cycle, clear busy, return to IDLE. The state after DONE is IDLE; a start_p in that cycle is accepted.
- Multiplier operation count: 3 + exp_size + popcount(exp[exp_size-1:0]).
- Controller overhead: 1 cycle per operation, plus 1 cycle for DONE.
- mul_done_irq_p outside a WAIT sub-phase is ignored.
- exp_size > EBITS is saturated to EBITS.
- Reset mid-operation: abort immediately; no done_irq_p; y returns to 0; no mul_enable_p until the next start.

Optional Feature:
- Macro: MONT_EXP_CONST_TIME_EN.
- When defined:
  - LOOP_MUL runs on every bit.
  - When exp[i]==0, the product is discarded (acc keeps its squared value).
  - Operation count becomes 3 + 2*exp_size, independent of the exponent value.
- When undefined: LOOP_MUL is skipped for zero bits, as described above.

Decomposition:
- Shared package mont_pkg:
  - state enum mont_exp_state_t.
  - constant MONT_ONE (NBITS-wide value 1).
  - width localparams for m_size and exp_size.
- One natural sub-module, mont_op_issue: the ISSUE/WAIT handshake unit.
  - Registers operands, generates the mul_enable_p pulse, returns an op_done pulse with the captured result.

Test Plan:
- m=13, base=3, exp=5, exp_size=3 -> y=9; exactly 8 mul_enable_p pulses; one done_irq_p; busy falls with done_irq_p.
- exp_size=0, m=13, base=7 -> y=1; 3 multiplier operations.
- exp=0xFF, exp_size=8, m=0xFFF1, base=2 -> y = 2^255 mod 65521 (bench model); 19 operations. With MONT_EXP_CONST_TIME_EN and exp=0x00: 19 operations, y=1.
- Second start_p issued mid-run -> ignored; result equals the first job's; exactly one done_irq_p.
- rst_n asserted during LOOP_SQ -> all outputs 0 next edge. A new start after release -> correct result; the stale mul_done_irq_p from the aborted operation is ignored.
- Spurious mul_done_irq_p in IDLE, and during an ISSUE cycle -> no state change, no capture.
